// File: rtl/ramif_nibble_bridge.sv
// Serialises 16-bit read addresses onto a narrow RAM pin interface and
// reassembles the returned data nibbles into a full response word.
module ramif_nibble_bridge #(
  parameter int RAMIF_WIDTH  = 4,
  parameter int ADDR_BITS    = 16,
  parameter int DATA_BITS    = 16,
  parameter int READ_LATENCY = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [ADDR_BITS-1:0]   req_addr,
  output logic                   rsp_valid,
  output logic [DATA_BITS-1:0]   rsp_data,
  output logic [RAMIF_WIDTH-1:0] addr_bits,
  output logic                   addr_start,
  input  logic [RAMIF_WIDTH-1:0] data_bits
);

  localparam int AN  = ADDR_BITS / RAMIF_WIDTH;
  localparam int DN  = DATA_BITS / RAMIF_WIDTH;
  localparam int M1  = (AN > DN) ? AN : DN;
  localparam int MX  = (M1 > READ_LATENCY) ? M1 : READ_LATENCY;
  localparam int CW  = $clog2(MX + 1);
  localparam int RLL = (READ_LATENCY > 0) ? READ_LATENCY - 1 : 0;

  localparam logic [CW-1:0] AN_C  = CW'(AN);
  localparam logic [CW-1:0] DN_L  = CW'(DN - 1);
  localparam logic [CW-1:0] RL_L  = CW'(RLL);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    WAIT,
    DATA
  } state_t;

  state_t                 state;
  logic [CW-1:0]          cnt;
  logic [ADDR_BITS-1:0]   addr_q;
  logic [DATA_BITS-1:0]   shadow;
  logic [DATA_BITS-1:0]   word;

  // Shadow word with the nibble arriving this cycle merged in.
  always_comb begin
    word = shadow;
    word[cnt*RAMIF_WIDTH +: RAMIF_WIDTH] = data_bits;
  end

  // Request FSM: accept, shift address out, wait, gather data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      addr_q     <= '0;
      shadow     <= '0;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      addr_bits  <= '0;
      addr_start <= 1'b0;
    end else begin
      rsp_valid  <= 1'b0;
      addr_start <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q     <= req_addr;
            addr_bits  <= req_addr[RAMIF_WIDTH-1:0];
            addr_start <= 1'b1;
            req_ready  <= 1'b0;
            cnt        <= CW'(1);
            state      <= ADDR;
          end
        end
        ADDR: begin
          if (cnt == AN_C) begin
            addr_bits <= '0;
            cnt       <= '0;
            state     <= (READ_LATENCY > 0) ? WAIT : DATA;
          end else begin
            addr_bits <= addr_q[cnt*RAMIF_WIDTH +: RAMIF_WIDTH];
            cnt       <= cnt + 1'b1;
          end
        end
        WAIT: begin
          if (cnt == RL_L) begin
            cnt   <= '0;
            state <= DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          shadow <= word;
          if (cnt == DN_L) begin
            rsp_data  <= word;
            rsp_valid <= 1'b1;
            req_ready <= 1'b1;
            cnt       <= '0;
            state     <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          cnt       <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ramif_nibble_bridge.sv
// Bench for ramif_nibble_bridge: default build plus a zero-latency build,
// table-driven reads, back-to-back, reset aborts and busy-input noise.
module tb_ramif_nibble_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_addr;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic [3:0]  addr_bits;
  logic        addr_start;
  logic [3:0]  data_bits;

  logic        v0;
  logic        rdy0;
  logic [15:0] a0;
  logic        rv0;
  logic [15:0] rd0;
  logic [3:0]  ab0;
  logic        as0;
  logic [3:0]  db0;

  int checks   = 0;
  int failures = 0;
  int rsp_cnt  = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  ramif_nibble_bridge dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .addr_bits  (addr_bits),
    .addr_start (addr_start),
    .data_bits  (data_bits)
  );

  ramif_nibble_bridge #(.READ_LATENCY(0)) dut0 (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (v0),
    .req_ready  (rdy0),
    .req_addr   (a0),
    .rsp_valid  (rv0),
    .rsp_data   (rd0),
    .addr_bits  (ab0),
    .addr_start (as0),
    .data_bits  (db0)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every response pulse must match the oldest pushed word.
  always @(negedge clk) begin
    if (!reset && rsp_valid) begin
      rsp_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected: got rsp %0h expected none", rsp_data);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (rsp_data !== e) begin
          failures++;
          $display("FAIL sb_data: got %0h expected %0h", rsp_data, e);
        end
      end
    end
  end

  // One full read, starting in cycle A with the bench at #1 after an edge.
  task automatic txn(input logic [15:0] addr, input logic [15:0] drv,
                     input logic [15:0] exp, input bit noisy);
    logic [15:0] a;
    a = addr;
    req_addr  = addr;
    req_valid = 1'b1;
    chk("accept_ready", req_ready, 1);
    exp_q.push_back(exp);
    step();
    if (!noisy) req_valid = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      if (noisy) begin
        req_valid = (k < 10) ? 1'($urandom) : 1'b0;
        req_addr  = 16'($urandom);
      end
      if (k <= 4) begin
        chk("addr_nib", addr_bits, a[(k-1)*4 +: 4]);
        chk("addr_start", addr_start, (k == 1));
      end else begin
        chk("addr_zero", addr_bits, 0);
      end
      chk("ready", req_ready, (k == 11));
      chk("rsp_valid", rsp_valid, (k == 11));
      if (k == 11) chk("rsp_data", rsp_data, exp);
      if (k >= 7 && k <= 10) data_bits = drv[(k-7)*4 +: 4];
      else data_bits = 4'($urandom);
      if (k < 11) step();
    end
    step();
    chk("rsp_hold", rsp_data, exp);
    chk("rsp_pulse_end", rsp_valid, 0);
  endtask

  typedef struct {
    logic [15:0] addr;
    logic [15:0] drv;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int base;
    vecs[0] = '{16'hA5C3, 16'h4321, 16'h4321};
    vecs[1] = '{16'h0000, 16'hFFFF, 16'hFFFF};
    vecs[2] = '{16'hFFFF, 16'h0000, 16'h0000};
    vecs[3] = '{16'h8001, 16'h1008, 16'h1008};

    reset = 1'b1; req_valid = 0; req_addr = 0; data_bits = 0;
    v0 = 0; a0 = 0; db0 = 0;
    #1;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_addr_bits", addr_bits, 0);
    chk("rst_addr_start", addr_start, 0);
    step(); step();
    reset = 1'b0;
    step();
    chk("rst_ready", req_ready, 1);

    for (int i = 0; i < 4; i++)
      txn(vecs[i].addr, vecs[i].drv, vecs[i].exp, 0);

    // Back-to-back with held valid; address change while busy ignored.
    req_valid = 1'b1; req_addr = 16'h1234;
    exp_q.push_back(16'h9ABC);
    step();
    req_addr = 16'h5678;
    for (int c = 1; c <= 22; c++) begin
      logic [15:0] x;
      x = 16'h1234;
      if (c <= 4) chk("b2b_nib1", addr_bits, x[(c-1)*4 +: 4]);
      x = 16'h5678;
      if (c >= 12 && c <= 15) chk("b2b_nib2", addr_bits, x[(c-12)*4 +: 4]);
      if (c <= 11) chk("b2b_ready", req_ready, (c == 11));
      if (c == 11) exp_q.push_back(16'hDEF0);
      if (c == 12) req_valid = 1'b0;
      x = 16'h9ABC;
      if (c >= 7 && c <= 10) data_bits = x[(c-7)*4 +: 4];
      x = 16'hDEF0;
      if (c >= 18 && c <= 21) data_bits = x[(c-18)*4 +: 4];
      if (c == 22) chk("b2b_rsp2", rsp_data, 16'hDEF0);
      step();
    end

    // Busy noise: exactly one response per accepted request.
    base = rsp_cnt;
    txn(16'h3C5A, 16'h7E81, 16'h7E81, 1);
    chk("noisy_one_rsp", rsp_cnt - base, 1);
    chk("noisy_queue_empty", exp_q.size(), 0);

    // Asynchronous reset mid-cycle during ADDR.
    req_addr = 16'h1357; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    chk("ar_start_pre", addr_start, 1);
    #2 reset = 1'b1;
    #1;
    chk("ar_addr_bits", addr_bits, 0);
    chk("ar_addr_start", addr_start, 0);
    chk("ar_rsp_valid", rsp_valid, 0);
    chk("ar_rsp_data", rsp_data, 0);
    step();
    reset = 1'b0;
    step();
    chk("ar_ready", req_ready, 1);

    // Reset pulse in WAIT aborts; next request starts from nibble 0.
    vecs[0] = '{16'h0000, 16'h0000, 16'h0000};
    req_addr = 16'h2468; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    for (int k = 1; k < 5; k++) step();
    chk("ab_in_wait", addr_bits, 0);
    #2 reset = 1'b1;
    #2 reset = 1'b0;
    base = rsp_cnt;
    for (int k = 0; k < 10; k++) begin
      data_bits = 4'($urandom);
      step();
    end
    chk("ab_no_rsp", rsp_cnt - base, 0);
    chk("ab_rsp_data", rsp_data, 0);
    txn(16'hBEEF, 16'h2C6B, 16'h2C6B, 0);

    // Zero read latency build.
    a0 = 16'h00FF; v0 = 1'b1;
    chk("rl0_ready", rdy0, 1);
    step();
    v0 = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      logic [15:0] x;
      x = 16'h00FF;
      if (k <= 4) chk("rl0_nib", ab0, x[(k-1)*4 +: 4]);
      chk("rl0_rsp_valid", rv0, (k == 9));
      x = 16'hCDEF;
      if (k >= 5 && k <= 8) db0 = x[(k-5)*4 +: 4];
      else db0 = 4'($urandom);
      if (k < 9) step();
    end
    chk("rl0_rsp_data", rd0, 16'hCDEF);
    chk("rl0_ready_back", rdy0, 1);
    step();
    chk("sb_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
